// File: rtl/lfsr_checker_if.sv
// lfsr_checker_if
//   Bundles the word stream into the checker and the status coming back out.
//   master : the source side (drives en/data_in/clr_cnt, observes status)
//   slave  : the checker side (consumes the stream, drives status)
//
//   Handshake: en is a pure valid qualifier for data_in. There is no ready;
//   the checker accepts one word on every rising clk edge where en=1 and
//   ignores data_in entirely while en=0.
//
//   Signals:
//     en        valid strobe for data_in
//     data_in   received 4-bit LFSR word
//     clr_cnt   synchronous clear of err_count
//     locked    high while the checker is locked to the stream
//     err       one-cycle pulse per mismatching word while locked
//     err_count saturating count of locked mismatches
interface lfsr_checker_if #(
  parameter int CNT_W = 16
);
  logic             en;
  logic [3:0]       data_in;
  logic             clr_cnt;
  logic             locked;
  logic             err;
  logic [CNT_W-1:0] err_count;

  modport master (
    output en, data_in, clr_cnt,
    input  locked, err, err_count
  );

  modport slave (
    input  en, data_in, clr_cnt,
    output locked, err, err_count
  );
endinterface

// File: rtl/lfsr_checker.sv
// lfsr_checker
//   Receive-side checker for a 4-bit maximal-length LFSR word stream
//   (successor {s[2:0], s[2]^s[3]}, period 15, 4'b0000 illegal).
//   Seeds from the first non-zero word, confirms LOCK_COUNT consecutive
//   correct predictions, then free-runs its own prediction and flags every
//   mismatching word. UNLOCK_COUNT consecutive mismatches drop lock.
//
//   Ports:
//     clk          single clock, all state on the rising edge
//     rst_n        asynchronous active-low reset
//     bus          lfsr_checker_if.slave (en, data_in, clr_cnt in;
//                  locked, err, err_count out)
//     dbg_state_o  current FSM state (0=SEED, 1=ACQUIRE, 2=LOCKED)
module lfsr_checker #(
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 3,
  parameter int CNT_W        = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  lfsr_checker_if.slave       bus,
  output logic [1:0]          dbg_state_o
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int UW = $clog2(UNLOCK_COUNT + 1);

  typedef enum logic [1:0] {
    SEED    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  function automatic logic [3:0] lfsr_next(input logic [3:0] s);
    return {s[2:0], s[2] ^ s[3]};
  endfunction

  state_t           state_q, state_d;
  logic [3:0]       exp_q, exp_d;
  logic [MW-1:0]    match_q, match_d, match_inc;
  logic [UW-1:0]    miss_q, miss_d, miss_inc;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEED;
      exp_q   <= 4'd0;
      match_q <= '0;
      miss_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      match_q <= match_d;
      miss_q  <= miss_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    match_d   = match_q;
    miss_d    = miss_q;
    err_d     = 1'b0;
    cnt_d     = cnt_q;
    match_inc = match_q + MW'(1);
    miss_inc  = miss_q + UW'(1);

    if (bus.en) begin
      unique case (state_q)
        SEED: begin
          // Zero is the lockup word and can never be a valid seed.
          if (bus.data_in != 4'd0) begin
            exp_d   = lfsr_next(bus.data_in);
            match_d = '0;
            state_d = ACQUIRE;
          end
        end
        ACQUIRE: begin
          if (bus.data_in == exp_q) begin
            match_d = match_inc;
            exp_d   = lfsr_next(bus.data_in);
            if (match_inc == MW'(LOCK_COUNT)) begin
              state_d = LOCKED;
              miss_d  = '0;
            end
          end else begin
            // Reseed from the offending word rather than restarting from
            // SEED, so a single slip costs only LOCK_COUNT more words.
            match_d = '0;
            if (bus.data_in != 4'd0) begin
              exp_d = lfsr_next(bus.data_in);
            end else begin
              state_d = SEED;
            end
          end
        end
        LOCKED: begin
          // Prediction free-runs so corrupted words cannot poison it.
          exp_d = lfsr_next(exp_q);
          if (bus.data_in == exp_q) begin
            miss_d = '0;
          end else begin
            err_d  = 1'b1;
            miss_d = miss_inc;
            if (cnt_q != '1) begin
              cnt_d = cnt_q + CNT_W'(1);
            end
            if (miss_inc == UW'(UNLOCK_COUNT)) begin
              state_d = SEED;
              match_d = '0;
            end
          end
        end
        default: state_d = SEED;
      endcase
    end

    // Clear wins over a coincident increment; it is a control input, so it
    // acts whether or not a word is presented this cycle.
    if (bus.clr_cnt) begin
      cnt_d = '0;
    end
  end

  assign bus.locked    = (state_q == LOCKED);
  assign bus.err       = err_q;
  assign bus.err_count = cnt_q;
  assign dbg_state_o   = state_q;

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Receive-side companion to the 4-bit LFSR pattern generator. Accepts the generator's 4-bit parallel word stream (one word per enabled cycle), self-synchronises to it, then predicts each following word and flags mismatches. Sits at the far end of a link or datapath under test and reports lock status and a saturating error count for bring-up and BIST.

## Interface
Parameters:
- LOCK_COUNT, 4: consecutive correct words in ACQUIRE needed to declare lock (≥1).
- UNLOCK_COUNT, 3: consecutive mismatching words in LOCKED that drop lock (≥1).
- CNT_W, 16: width of err_count.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  data_in valid this cycle; no state changes when low.
- data_in  input  4  received LFSR word.
- clr_cnt  input  1  synchronous clear of err_count.
- locked  output  1  high while in LOCKED state.
- err  output  1  one-cycle pulse, high after the edge that sampled a mismatching word in LOCKED.
- err_count  output  CNT_W  saturating count of LOCKED mismatches.

## Operation
- Successor function: next(s) = {s[2:0], s[2]^s[3]}; maximal length, period 15; 4'b0000 is illegal (lockup word).
- Registers: exp[3:0] (expected word), state, match_cnt, miss_cnt, err, err_count.
- States: SEED, ACQUIRE, LOCKED. All transitions only on edges with en=1.
- SEED: data_in≠0 → exp<=next(data_in), match_cnt<=0, go ACQUIRE. data_in=0 → stay in SEED.
- ACQUIRE: data_in==exp → match_cnt+1; exp<=next(data_in); if match_cnt+1==LOCK_COUNT → LOCKED, miss_cnt<=0. Mismatch → match_cnt<=0; data_in≠0: exp<=next(data_in), stay in ACQUIRE; data_in=0: go SEED. No errors counted in SEED/ACQUIRE.
- LOCKED: exp<=next(exp) every enabled word (free-running prediction, never reseeded from data_in). Match → miss_cnt<=0. Mismatch → err<=1, err_count saturating +1, miss_cnt+1; if miss_cnt+1==UNLOCK_COUNT → SEED, match_cnt<=0.
- err <= 0 on every edge except a LOCKED mismatch (including edges with en=0).
- err_count saturates at 2^CNT_W−1. clr_cnt=1 forces err_count<=0 and takes priority over a coincident increment; the err pulse is still produced.
- locked = (state==LOCKED), registered-state derived, glitch-free.

## Timing
- Reset (rst_n low, asynchronous, immediate): state=SEED, exp=0, match_cnt=0, miss_cnt=0, locked=0, err=0, err_count=0. Deassertion takes effect at the next clk edge. Reset mid-operation discards lock.
- Latency: word sampled at edge N → err/err_count/locked reflect it immediately after edge N (1-cycle registered).
- Lock after lossless start: 1 seed word + LOCK_COUNT matches → locked rises after the (LOCK_COUNT+1)th enabled word.
- Unlock: locked falls after the edge sampling the UNLOCK_COUNTth consecutive mismatch; err pulses on that same word.
- en gaps of any length: all state held, err low; the sequence resumes with the next enabled word.
- Back-to-back enabled words at full rate (en=1 every cycle) are supported; there is no backpressure.

## Test plan
- Lock: defaults, en=1, stream 0001,0010,0100,1001,0011,0110,… → locked=0 through the 4th word, locked=1 after the 5th (0011), err never asserted, err_count=0.
- Single error: locked, send 0111 in place of 0110, then 1101,1010 → err high for exactly one cycle, err_count=1, locked stays 1, no error on 1101.
- Burst/unlock: locked, three consecutive corrupted words → err_count=3, locked=0 after the third; then a correct stream → locked=1 after 5 further words, err_count holds 3.
- en gaps and zero word: in SEED, present 0000 with en=1 → state stays SEED; then the lock stream with random en=0 cycles interleaved (data_in garbage while en=0) → lock reached after exactly 5 enabled words.
- Counter rules: CNT_W=2, force 5 LOCKED mismatches (UNLOCK_COUNT=8) → err_count stays at 3; assert clr_cnt on a mismatch cycle → err_count=0, err=1.
- Async reset: while locked with err_count=2, pulse rst_n low between clock edges → locked=0, err=0, err_count=0 before the next edge; relock after 5 words.
